// File: rtl/mmio_timer.sv
// mmio_timer: free-running memory-mapped timer with NUM_CH compare channels.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en_in, r_nw_in      byte access strobe, 1 = read / 0 = write
//   a_in, d_in          byte address (bits [6:0] decoded), write data
//   d_out               registered read data (1-cycle latency)
//   irq_ack             clears all pending bits
//   irq                 registered level interrupt, OR of pending & ie
module mmio_timer #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_in,
  input  logic                  r_nw_in,
  input  logic [ADDR_WIDTH-1:0] a_in,
  input  logic [7:0]            d_in,
  output logic [7:0]            d_out,
  input  logic                  irq_ack,
  output logic                  irq
);

  localparam int unsigned NB        = CNT_WIDTH / 8;
  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [CNT_WIDTH-1:0] r_mtime, w_mtime_nxt, w_mtime_p1;
  logic [15:0]          r_presc, w_presc_nxt;
  logic [23:0]          r_shadow, w_shadow_nxt;
  logic                 r_run, w_run_nxt;
  logic [NUM_CH-1:0]    r_pend, w_pend_nxt, r_ie, w_ie_nxt;
  logic [NUM_CH-1:0]    r_en, w_en_nxt, r_per, w_per_nxt, w_match;
  logic [CNT_WIDTH-1:0] r_cmp [NUM_CH];
  logic [CNT_WIDTH-1:0] w_cmp_nxt [NUM_CH];
  logic [CNT_WIDTH-1:0] r_period [NUM_CH];
  logic [CNT_WIDTH-1:0] w_period_nxt [NUM_CH];
  logic [7:0]           r_dout, w_dout_nxt, w_rdata;
  logic                 r_irq, w_irq_nxt;

  logic [6:0]           w_addr;
  logic [4:0]           w_bsel;
  logic                 w_wr, w_rd, w_tick, w_mt_wr, w_sel;
  logic [31:0]          w_mt32, w_tmp, w_rd32;
  logic [ADDR_WIDTH-1:0] w_unused_addr;

  // Address bits above [6:0] are intentionally not decoded.
  assign w_unused_addr = a_in;

  assign d_out = r_dout;
  assign irq   = r_irq;

  // Next-state and read-mux logic.
  always_comb begin
    w_addr       = a_in[6:0];
    w_bsel       = {w_addr[1:0], 3'b000};
    w_wr         = en_in & ~r_nw_in;
    w_rd         = en_in & r_nw_in;
    w_mt32       = 32'(r_mtime);
    w_tick       = r_run & (r_presc == PRESC_MAX);
    w_mt_wr      = w_wr & (w_addr[6:2] == 5'd0) & (3'(w_addr[1:0]) < 3'(NB));
    w_mtime_p1   = r_mtime + CNT_WIDTH'(1);
    w_mtime_nxt  = r_mtime;
    w_presc_nxt  = r_presc;
    w_shadow_nxt = r_shadow;
    w_run_nxt    = r_run;
    w_ie_nxt     = r_ie;
    w_pend_nxt   = r_pend;
    w_en_nxt     = r_en;
    w_per_nxt    = r_per;
    w_match      = '0;
    w_tmp        = 32'd0;
    w_rd32       = 32'd0;
    w_sel        = 1'b0;
    w_rdata      = 8'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cmp_nxt[i]    = r_cmp[i];
      w_period_nxt[i] = r_period[i];
    end

    if (r_run) w_presc_nxt = w_tick ? 16'd0 : r_presc + 16'd1;

    // A software byte write to mtime replaces the byte and blocks the tick.
    if (w_mt_wr) begin
      w_tmp              = w_mt32;
      w_tmp[w_bsel +: 8] = d_in;
      w_mtime_nxt        = CNT_WIDTH'(w_tmp);
    end else if (w_tick) begin
      w_mtime_nxt = w_mtime_p1;
    end

    // Reading byte 0 snapshots the upper bytes for coherent multi-byte reads.
    if (w_rd && w_addr == 7'h00) w_shadow_nxt = w_mt32[31:8];
    if (w_wr && w_addr == 7'h04) w_run_nxt = d_in[0];
    if (w_wr && w_addr == 7'h06) w_ie_nxt = NUM_CH'(d_in);
    if (irq_ack) w_pend_nxt = '0;
    if (w_wr && w_addr == 7'h05) w_pend_nxt = w_pend_nxt & ~NUM_CH'(d_in);

    if (w_addr[6:2] == 5'd0) begin
      w_rd32  = (w_addr[1:0] == 2'd0) ? w_mt32 : {r_shadow, 8'h00};
      w_rdata = w_rd32[w_bsel +: 8];
    end else if (w_addr == 7'h04) begin
      w_rdata = {7'd0, r_run};
    end else if (w_addr == 7'h05) begin
      w_rdata = 8'(r_pend);
    end else if (w_addr == 7'h06) begin
      w_rdata = 8'(r_ie);
    end

    for (int i = 0; i < NUM_CH; i++) begin
      w_sel      = (w_addr[6:4] == 3'(i + 1));
      w_match[i] = w_tick & ~w_mt_wr & r_en[i] & (w_mtime_p1 == r_cmp[i]);
      // Match is applied last so it wins over W1C and irq_ack.
      if (w_match[i]) w_pend_nxt[i] = 1'b1;

      // Software cmp write takes priority over the periodic reload.
      if (w_wr && w_sel && w_addr[3:2] == 2'd0) begin
        w_tmp              = 32'(r_cmp[i]);
        w_tmp[w_bsel +: 8] = d_in;
        w_cmp_nxt[i]       = CNT_WIDTH'(w_tmp);
      end else if (w_match[i] && r_per[i]) begin
        w_cmp_nxt[i] = r_cmp[i] + r_period[i];
      end

      if (w_wr && w_sel && w_addr[3:2] == 2'd1) begin
        w_tmp              = 32'(r_period[i]);
        w_tmp[w_bsel +: 8] = d_in;
        w_period_nxt[i]    = CNT_WIDTH'(w_tmp);
      end

      // Software chctrl write takes priority over the one-shot disable.
      if (w_wr && w_sel && w_addr[3:0] == 4'h8) begin
        w_en_nxt[i]  = d_in[0];
        w_per_nxt[i] = d_in[1];
      end else if (w_match[i] && !r_per[i]) begin
        w_en_nxt[i] = 1'b0;
      end

      if (w_sel) begin
        if (w_addr[3:2] == 2'd0) begin
          w_rd32  = 32'(r_cmp[i]);
          w_rdata = w_rd32[w_bsel +: 8];
        end else if (w_addr[3:2] == 2'd1) begin
          w_rd32  = 32'(r_period[i]);
          w_rdata = w_rd32[w_bsel +: 8];
        end else if (w_addr[3:0] == 4'h8) begin
          w_rdata = {6'd0, r_per[i], r_en[i]};
        end
      end
    end

    w_irq_nxt  = |(w_pend_nxt & w_ie_nxt);
    w_dout_nxt = w_rd ? w_rdata : r_dout;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime  <= '0;
      r_presc  <= '0;
      r_shadow <= '0;
      r_run    <= 1'b0;
      r_pend   <= '0;
      r_ie     <= '0;
      r_en     <= '0;
      r_per    <= '0;
      r_dout   <= '0;
      r_irq    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cmp[i]    <= '0;
        r_period[i] <= '0;
      end
    end else begin
      r_mtime  <= w_mtime_nxt;
      r_presc  <= w_presc_nxt;
      r_shadow <= w_shadow_nxt;
      r_run    <= w_run_nxt;
      r_pend   <= w_pend_nxt;
      r_ie     <= w_ie_nxt;
      r_en     <= w_en_nxt;
      r_per    <= w_per_nxt;
      r_dout   <= w_dout_nxt;
      r_irq    <= w_irq_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cmp[i]    <= w_cmp_nxt[i];
        r_period[i] <= w_period_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed bench for mmio_timer. Two instances share the bus:
// u_dut (2 channels, 32-bit, prescale 1) and u_dut8 (1 channel, 8-bit, prescale 4).
module tb_mmio_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       r_nw = 1'b1;
  logic [6:0] a = 7'd0;
  logic [7:0] d = 8'd0;
  logic       irq_ack = 1'b0;
  logic [7:0] d_out32, d_out8;
  logic       irq32, irq8;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit         wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] e32;
    logic [7:0] e8;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  mmio_timer #(.NUM_CH(2), .CNT_WIDTH(32), .PRESCALE(1), .ADDR_WIDTH(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_in(en), .r_nw_in(r_nw), .a_in(a), .d_in(d),
    .d_out(d_out32), .irq_ack(irq_ack), .irq(irq32)
  );

  mmio_timer #(.NUM_CH(1), .CNT_WIDTH(8), .PRESCALE(4), .ADDR_WIDTH(7)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en_in(en), .r_nw_in(r_nw), .a_in(a), .d_in(d),
    .d_out(d_out8), .irq_ack(irq_ack), .irq(irq8)
  );

  function automatic vec_t v(bit w, logic [6:0] ad, logic [7:0] da,
                             logic [7:0] x32, logic [7:0] x8);
    vec_t r;
    r.wr = w; r.addr = ad; r.data = da; r.e32 = x32; r.e8 = x8;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // All bus tasks start right after a falling edge and return one cycle later.
  task automatic wr(input logic [6:0] ad, input logic [7:0] da);
    en = 1'b1; r_nw = 1'b0; a = ad; d = da;
    @(negedge clk);
    en = 1'b0; r_nw = 1'b1;
  endtask

  task automatic rd(input logic [6:0] ad);
    en = 1'b1; r_nw = 1'b1; a = ad;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    en = 1'b0; irq_ack = 1'b0; rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_irq32", 8'(irq32), 8'h00);
    chk("reset_irq8", 8'(irq8), 8'h00);
    chk("reset_dout32", d_out32, 8'h00);

    // Register map, masking and out-of-range behaviour with the timer stopped.
    tbl.push_back(v(1'b0, 7'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h04, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h05, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(1'b1, 7'h06, 8'hFF, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h06, 8'h00, 8'h03, 8'h01));
    tbl.push_back(v(1'b1, 7'h10, 8'hA5, 8'h00, 8'h00));
    tbl.push_back(v(1'b1, 7'h11, 8'h5A, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h10, 8'h00, 8'hA5, 8'hA5));
    tbl.push_back(v(1'b0, 7'h11, 8'h00, 8'h5A, 8'h00));
    tbl.push_back(v(1'b1, 7'h18, 8'hFF, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h18, 8'h00, 8'h03, 8'h03));
    tbl.push_back(v(1'b1, 7'h20, 8'h77, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h20, 8'h00, 8'h77, 8'h00));
    tbl.push_back(v(1'b1, 7'h30, 8'h11, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h30, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(1'b1, 7'h07, 8'hFF, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h07, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(1'b1, 7'h04, 8'hFE, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h04, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(1'b1, 7'h17, 8'h9C, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h17, 8'h00, 8'h9C, 8'h00));
    tbl.push_back(v(1'b1, 7'h02, 8'h12, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h00, 8'h00, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 7'h02, 8'h00, 8'h12, 8'h00));

    foreach (tbl[k]) begin
      if (tbl[k].wr) begin
        wr(tbl[k].addr, tbl[k].data);
      end else begin
        rd(tbl[k].addr);
        chk($sformatf("tbl%0d_a%02h_d32", k, tbl[k].addr), d_out32, tbl[k].e32);
        chk($sformatf("tbl%0d_a%02h_d8", k, tbl[k].addr), d_out8, tbl[k].e8);
      end
    end
    idle(2);
    chk("tbl_hold_d32", d_out32, 8'h12);

    // One-shot match on channel 0, then reset while irq is high.
    do_reset();
    wr(7'h10, 8'd5); wr(7'h18, 8'h01); wr(7'h06, 8'h01); wr(7'h04, 8'h01);
    idle(4);
    chk("oneshot_irq_before", 8'(irq32), 8'h00);
    idle(1);
    chk("oneshot_irq_at5", 8'(irq32), 8'h01);
    rd(7'h18);
    chk("oneshot_chctrl_cleared", d_out32, 8'h00);
    rd(7'h05);
    chk("oneshot_pending", d_out32, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("midrst_irq", 8'(irq32), 8'h00);
    chk("midrst_dout", d_out32, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rd(7'h00);
    chk("midrst_mtime", d_out32, 8'h00);
    rd(7'h18);
    chk("midrst_chctrl", d_out32, 8'h00);
    idle(20);
    chk("midrst_no_irq", 8'(irq32), 8'h00);

    // Periodic channel 1 with W1C between matches.
    do_reset();
    wr(7'h20, 8'd10); wr(7'h24, 8'd10); wr(7'h28, 8'h03); wr(7'h06, 8'h02); wr(7'h04, 8'h01);
    idle(9);
    chk("per_irq_t9", 8'(irq32), 8'h00);
    idle(1);
    chk("per_irq_t10", 8'(irq32), 8'h01);
    wr(7'h05, 8'h02);
    chk("per_w1c_t11", 8'(irq32), 8'h00);
    idle(8);
    chk("per_irq_t19", 8'(irq32), 8'h00);
    idle(1);
    chk("per_irq_t20", 8'(irq32), 8'h01);
    wr(7'h05, 8'h02);
    idle(8);
    chk("per_irq_t29", 8'(irq32), 8'h00);
    idle(1);
    chk("per_irq_t30", 8'(irq32), 8'h01);
    rd(7'h20);
    chk("per_cmp_reload", d_out32, 8'd40);

    // W1C plus irq_ack colliding with a new channel-0 match.
    do_reset();
    wr(7'h10, 8'd5); wr(7'h14, 8'd5); wr(7'h18, 8'h03); wr(7'h06, 8'h01); wr(7'h04, 8'h01);
    idle(5);
    chk("coll_irq_t5", 8'(irq32), 8'h01);
    idle(4);
    en = 1'b1; r_nw = 1'b0; a = 7'h05; d = 8'h01; irq_ack = 1'b1;
    @(negedge clk);
    en = 1'b0; r_nw = 1'b1; irq_ack = 1'b0;
    chk("coll_irq_t10", 8'(irq32), 8'h01);
    rd(7'h05);
    chk("coll_pending", d_out32, 8'h01);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("ack_irq", 8'(irq32), 8'h00);
    rd(7'h05);
    chk("ack_pending", d_out32, 8'h00);

    // 8-bit wrap with prescale 4.
    do_reset();
    wr(7'h00, 8'hFE); wr(7'h10, 8'h01); wr(7'h18, 8'h01); wr(7'h06, 8'h01); wr(7'h04, 8'h01);
    rd(7'h00);
    chk("wrap_t1", d_out8, 8'hFE);
    idle(2);
    rd(7'h00);
    chk("wrap_t4_pre", d_out8, 8'hFE);
    rd(7'h00);
    chk("wrap_t5", d_out8, 8'hFF);
    idle(3);
    rd(7'h00);
    chk("wrap_t9", d_out8, 8'h00);
    chk("wrap_irq_t9", 8'(irq8), 8'h00);
    idle(2);
    chk("wrap_irq_t11", 8'(irq8), 8'h00);
    idle(1);
    chk("wrap_irq_t12", 8'(irq8), 8'h01);

    // 8-bit periodic reload wrapping past 0xFF.
    do_reset();
    wr(7'h00, 8'hEF); wr(7'h10, 8'hF0); wr(7'h14, 8'h20); wr(7'h18, 8'h03); wr(7'h04, 8'h01);
    idle(4);
    rd(7'h10);
    chk("wrapper_cmp", d_out8, 8'h10);
    rd(7'h05);
    chk("wrapper_pending", d_out8, 8'h01);

    // Snapshot coherence, mtime write suppression and run freeze.
    do_reset();
    wr(7'h00, 8'hFF);
    rd(7'h00);
    chk("snap_lsb", d_out32, 8'hFF);
    wr(7'h04, 8'h01);
    idle(3);
    rd(7'h01);
    chk("snap_shadow", d_out32, 8'h00);
    rd(7'h00);
    chk("snap_lsb2", d_out32, 8'h03);
    rd(7'h01);
    chk("snap_shadow2", d_out32, 8'h01);
    wr(7'h00, 8'h40);
    rd(7'h00);
    chk("mtwr_no_inc", d_out32, 8'h40);
    wr(7'h04, 8'h00);
    idle(3);
    rd(7'h00);
    chk("freeze", d_out32, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
